// File: rtl/text_decryption.sv
// -----------------------------------------------------------------------------
// text_decryption
//
// Board-level controller for the decryption direction of the DES text flow.
// The user keys in a 64-bit key and a 64-bit ciphertext as four 16-bit switch
// words each (most significant word first) and reviews both on the 7-segment
// display. The block then starts an external iterative DES core with a
// start/done handshake and shows the recovered plaintext.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in BUSY for core_done before ERROR
//
// Optional feature macro:
//   KEY_PARITY_CHECK_EN  when defined, leaving DISP_KEY checks every key byte
//                        for DES odd parity; any even byte sends the FSM to
//                        ERROR instead of ciphertext entry.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   send_data       entry button (active-low), acts on release
//   change_state    review-advance button (active-low), acts on release
//   decr_go         decrypt button (active-low), acts on release
//   user_input      16-bit switch word
//   select_disp     review/result word select: 0=[15:0] ... 3=[63:48]
//   disp            word shown on the 7-segment display
//   key_led/ct_led  high while reviewing key / ciphertext
//   decr_led        high once the plaintext is available
//   err_led         high in ERROR (timeout, bad parity, illegal state)
//   core_start      one-cycle start pulse to the DES core
//   core_key/data   key and ciphertext presented to the core
//   core_done       core completion pulse
//   core_result     plaintext from the core, valid with core_done
// -----------------------------------------------------------------------------
module text_decryption #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_data,
  input  logic        change_state,
  input  logic        decr_go,
  input  logic [15:0] user_input,
  input  logic [1:0]  select_disp,
  output logic [15:0] disp,
  output logic        key_led,
  output logic        ct_led,
  output logic        decr_led,
  output logic        err_led,
  output logic        core_start,
  output logic [63:0] core_key,
  output logic [63:0] core_data,
  input  logic        core_done,
  input  logic [63:0] core_result
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value during the final BUSY cycle before the timeout fires.
  localparam logic [CW-1:0] LAST_BUSY = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_KEY_ENTRY = 4'd0,
    S_DISP_KEY  = 4'd1,
    S_CT_ENTRY  = 4'd2,
    S_DISP_CT   = 4'd3,
    S_WAIT_GO   = 4'd4,
    S_START     = 4'd5,
    S_BUSY      = 4'd6,
    S_DONE      = 4'd7,
    S_ERROR     = 4'd8
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic            r_send_now, r_send_prev;
  logic            r_chg_now,  r_chg_prev;
  logic            r_go_now,   r_go_prev;
  logic            w_send_rel, w_chg_rel, w_go_rel;

  logic [1:0]      r_idx;
  logic [63:0]     r_key, r_ct, r_result;
  logic [15:0]     r_disp;
  logic            r_key_led, r_ct_led, r_decr_led, r_err_led;
  logic [CW-1:0]   r_cnt;

  logic            w_core_start;
  logic            w_key_parity_ok;
  logic [5:0]      w_entry_lsb;
  logic [5:0]      w_view_lsb;

  // Buttons are active-low, so a release is a 0 -> 1 transition of the
  // registered level. Acting only on release means a held button fires once.
  assign w_send_rel = r_send_now & ~r_send_prev;
  assign w_chg_rel  = r_chg_now  & ~r_chg_prev;
  assign w_go_rel   = r_go_now   & ~r_go_prev;

  // Entry order is MSW first: idx 0 writes [63:48], so lsb = (3 - idx) * 16.
  assign w_entry_lsb = {~r_idx, 4'b0000};
  assign w_view_lsb  = {select_disp, 4'b0000};

`ifdef KEY_PARITY_CHECK_EN
  // DES keys carry odd parity per byte; a byte with an even bit count fails.
  always_comb begin
    w_key_parity_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (!(^r_key[b*8 +: 8])) w_key_parity_ok = 1'b0;
    end
  end
`else
  assign w_key_parity_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so all registers
  // sample the same pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_KEY_ENTRY;
    else     r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and combinational outputs
  // ---------------------------------------------------------------------------
  // NOTE: defaults are assigned before the case so no path leaves a variable
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_core_start = 1'b0;
    case (r_state)
      S_KEY_ENTRY: if (w_send_rel && r_idx == 2'd3) w_next_state = S_DISP_KEY;
      S_DISP_KEY:  if (w_chg_rel) w_next_state = w_key_parity_ok ? S_CT_ENTRY : S_ERROR;
      S_CT_ENTRY:  if (w_send_rel && r_idx == 2'd3) w_next_state = S_DISP_CT;
      S_DISP_CT:   if (w_chg_rel) w_next_state = S_WAIT_GO;
      S_WAIT_GO:   if (w_go_rel)  w_next_state = S_START;
      S_START: begin
        w_core_start = 1'b1;
        w_next_state = S_BUSY;
      end
      S_BUSY: begin
        // A completion arriving on the expiry cycle still counts as success.
        if (core_done)               w_next_state = S_DONE;
        else if (r_cnt == LAST_BUSY) w_next_state = S_ERROR;
      end
      S_DONE:      w_next_state = S_DONE;
      S_ERROR:     w_next_state = S_ERROR;
      default:     w_next_state = S_ERROR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: button history, word capture, timeout counter, display, LEDs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_send_now  <= 1'b1;
      r_send_prev <= 1'b1;
      r_chg_now   <= 1'b1;
      r_chg_prev  <= 1'b1;
      r_go_now    <= 1'b1;
      r_go_prev   <= 1'b1;
      r_idx       <= '0;
      r_key       <= '0;
      r_ct        <= '0;
      r_result    <= '0;
      r_disp      <= '0;
      r_key_led   <= 1'b0;
      r_ct_led    <= 1'b0;
      r_decr_led  <= 1'b0;
      r_err_led   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_send_now  <= send_data;
      r_send_prev <= r_send_now;
      r_chg_now   <= change_state;
      r_chg_prev  <= r_chg_now;
      r_go_now    <= decr_go;
      r_go_prev   <= r_go_now;

      // LEDs follow the registered state, so they lag state entry by a cycle.
      r_key_led   <= (r_state == S_DISP_KEY);
      r_ct_led    <= (r_state == S_DISP_CT);
      r_decr_led  <= (r_state == S_DONE);
      r_err_led   <= (r_state == S_ERROR);

      case (r_state)
        S_KEY_ENTRY: begin
          // The release cycle itself does not write, so the word keeps the
          // value captured at press; idx wraps 3 -> 0 for the next entry.
          if (w_send_rel) begin
            r_idx <= r_idx + 2'd1;
          end else if (r_send_now) begin
            r_key[w_entry_lsb +: 16] <= user_input;
            r_disp                   <= user_input;
          end
        end
        S_CT_ENTRY: begin
          if (w_send_rel) begin
            r_idx <= r_idx + 2'd1;
          end else if (r_send_now) begin
            r_ct[w_entry_lsb +: 16] <= user_input;
            r_disp                  <= user_input;
          end
        end
        S_DISP_KEY: r_disp <= r_key[w_view_lsb +: 16];
        S_DISP_CT:  r_disp <= r_ct[w_view_lsb +: 16];
        S_WAIT_GO:  r_disp <= '0;
        S_START: begin
          r_cnt  <= '0;
          r_disp <= '0;
        end
        S_BUSY: begin
          r_cnt  <= r_cnt + CW'(1);
          r_disp <= '0;
          if (core_done) r_result <= core_result;
        end
        S_DONE:     r_disp <= r_result[w_view_lsb +: 16];
        default:    r_disp <= 16'hEEEE;
      endcase
    end
  end

  assign disp       = r_disp;
  assign key_led    = r_key_led;
  assign ct_led     = r_ct_led;
  assign decr_led   = r_decr_led;
  assign err_led    = r_err_led;
  assign core_start = w_core_start;
  assign core_key   = r_key;
  assign core_data  = r_ct;

endmodule
